// File: rtl/gated_edge_counter.sv
// Gated edge counter: counts synchronised rising edges of sig_in while gate is high,
// then publishes the saturated total with a one-cycle valid pulse when gate falls.
module gated_edge_counter #(
   parameter int COUNT_WIDTH = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   gate,
   input  logic                   sig_in,
   output logic [COUNT_WIDTH-1:0] count_out,
   output logic                   count_valid,
   output logic                   overflow,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      COUNT = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;
   logic                   gate_d;
   logic [COUNT_WIDTH-1:0] counter;
   logic                   ovf;

   logic s_sync;
   logic sig_edge;
   logic gate_rise;
   logic gate_fall;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Synchroniser, edge-detect register and gate history
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         s_d    <= 1'b0;
         gate_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_d    <= s_sync;
         gate_d <= gate;
      end
   end

   assign s_sync    = sync_q[SYNC_STAGES-1];
   assign sig_edge  = s_sync & ~s_d;
   assign gate_rise = gate & ~gate_d;
   assign gate_fall = ~gate & gate_d;

   // Window control: IDLE drops a window already open at reset release
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         counter     <= '0;
         ovf         <= 1'b0;
         count_out   <= '0;
         overflow    <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!gate) state <= ARMED;
            end
            ARMED: begin
               if (gate_rise) begin
                  counter <= {{(COUNT_WIDTH-1){1'b0}}, sig_edge};
                  ovf     <= 1'b0;
                  state   <= COUNT;
               end
            end
            COUNT: begin
               if (gate_fall) begin
                  count_out   <= counter;
                  overflow    <= ovf;
                  count_valid <= 1'b1;
                  state       <= ARMED;
               end else if (sig_edge) begin
                  counter <= sat_inc(counter);
                  ovf     <= ovf | (counter == CNT_MAX);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == COUNT);

endmodule

// File: tb/tb_gated_edge_counter.sv
// Randomised bench for gated_edge_counter: a window-summing reference model
// predicts every output each cycle, plus directed checks of the edge cases.
module tb_gated_edge_counter;

   localparam int CW   = 8;
   localparam int S    = 2;
   localparam int MAXV = (1 << CW) - 1;

   logic          clock  = 1'b0;
   logic          reset  = 1'b0;
   logic          gate   = 1'b0;
   logic          sig_in = 1'b0;
   logic [CW-1:0] count_out;
   logic          count_valid;
   logic          overflow;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   gated_edge_counter #(.COUNT_WIDTH(CW), .SYNC_STAGES(S)) dut (
      .clock      (clock),
      .reset      (reset),
      .gate       (gate),
      .sig_in     (sig_in),
      .count_out  (count_out),
      .count_valid(count_valid),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference model: input history since reset, windows summed when they close
   bit sig_h[$];
   bit gate_h[$];
   int cur_start = 0;
   bit cur_ok    = 1'b0;
   bit exp_valid = 1'b0;
   bit exp_busy  = 1'b0;
   bit exp_ovf   = 1'b0;
   int exp_cnt   = 0;

   function automatic int samp(input int i);
      return (i < 0) ? 0 : int'(sig_h[i]);
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         sig_h.delete();
         gate_h.delete();
         cur_start = 0;
         cur_ok    = 1'b0;
         exp_valid = 1'b0;
         exp_busy  = 1'b0;
         exp_ovf   = 1'b0;
         exp_cnt   = 0;
      end else begin
         int n;
         int total;
         sig_h.push_back(sig_in);
         gate_h.push_back(gate);
         n = gate_h.size() - 1;
         exp_valid = 1'b0;
         if (gate_h[n] && (n == 0 || !gate_h[n-1])) begin
            cur_start = n;
            cur_ok    = (n >= 1);
         end
         if (!gate_h[n] && n >= 1 && gate_h[n-1] && cur_ok) begin
            total = 0;
            for (int m = cur_start; m < n; m++)
               total += (samp(m - S) == 1 && samp(m - S - 1) == 0) ? 1 : 0;
            exp_valid = 1'b1;
            exp_cnt   = (total > MAXV) ? MAXV : total;
            exp_ovf   = (total > MAXV);
         end
         if (!gate_h[n]) cur_ok = 1'b0;
         exp_busy = gate_h[n] && cur_ok;
      end
   end

   int n_valid  = 0;
   int last_cnt = 0;
   int last_ovf = 0;

   always @(negedge clock) begin
      check("valid", count_valid, exp_valid);
      check("busy", busy, exp_busy);
      check("count_out", count_out, exp_cnt);
      check("overflow", overflow, exp_ovf);
      if (count_valid) begin
         n_valid++;
         last_cnt = count_out;
         last_ovf = overflow;
      end
   end

   // Stimulus: sig_mode 0 = hold, 1 = square wave (half period 'half'), 2 = random
   int sig_mode = 0;
   int half     = 2;
   int phase    = 0;

   task automatic step(input logic g);
      @(negedge clock);
      gate = g;
      case (sig_mode)
         1: begin
            if (phase >= half - 1) begin
               sig_in = ~sig_in;
               phase  = 0;
            end else begin
               phase++;
            end
         end
         2: sig_in = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic run(input logic g, input int n);
      for (int i = 0; i < n; i++) step(g);
   endtask

   initial begin
      int v0;
      repeat (3) @(negedge clock);
      check("rst_count_out", count_out, 0);
      check("rst_valid", count_valid, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);
      @(posedge clock); #3 reset = 1'b1;
      run(0, 5);

      // 12.5 MHz input over a 1000-cycle window
      sig_mode = 1; half = 2; phase = 0;
      v0 = n_valid;
      run(1, 1000); run(0, 5);
      check("basic_nvalid", n_valid - v0, 1);
      check("basic_range", (last_cnt >= 249 && last_cnt <= 251), 1);
      check("basic_ovf", last_ovf, 0);

      // static input
      sig_mode = 0; sig_in = 1'b0;
      run(0, 5);
      v0 = n_valid;
      run(1, 500); run(0, 5);
      check("zero_nvalid", n_valid - v0, 1);
      check("zero_cnt", last_cnt, 0);
      check("zero_ovf", last_ovf, 0);

      // saturation then recovery
      sig_mode = 1; half = 2; phase = 0;
      run(1, 1600); run(0, 5);
      check("sat_cnt", last_cnt, MAXV);
      check("sat_ovf", last_ovf, 1);
      run(1, 40); run(0, 5);
      check("post_sat_cnt", last_cnt, 10);
      check("post_sat_ovf", last_ovf, 0);

      // reset released with gate already high: first window discarded
      @(posedge clock); #3 reset = 1'b0;
      step(1);
      @(posedge clock); #3 reset = 1'b1;
      v0 = n_valid;
      run(1, 200); run(0, 3);
      check("discard_nvalid", n_valid - v0, 0);
      run(1, 400); run(0, 3);
      check("after_discard_nvalid", n_valid - v0, 1);
      check("after_discard_range", (last_cnt >= 99 && last_cnt <= 101), 1);

      // asynchronous reset in the middle of a window
      run(1, 300);
      @(posedge clock); #3 reset = 1'b0;
      #1;
      check("midrst_count_out", count_out, 0);
      check("midrst_valid", count_valid, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_busy", busy, 0);
      v0 = n_valid;
      run(0, 3);
      @(posedge clock); #3 reset = 1'b1;
      run(0, 5);
      check("midrst_nvalid", n_valid - v0, 0);

      // back-to-back windows and one-cycle gate pulses
      sig_mode = 2;
      v0 = n_valid;
      run(1, 30); run(0, 1); run(1, 30); run(0, 3);
      check("b2b_nvalid", n_valid - v0, 2);
      v0 = n_valid;
      run(1, 1); run(0, 1); run(1, 1); run(0, 3);
      check("short_nvalid", n_valid - v0, 2);

      // edge landing exactly on the gate_rise cycle is counted
      sig_mode = 0; sig_in = 1'b0;
      run(0, 6);
      sig_in = 1'b1;
      run(0, S - 1); run(1, 5); run(0, 5);
      check("rise_aligned_cnt", last_cnt, 1);

      // edge landing exactly on the gate_fall cycle is not counted
      sig_in = 1'b0;
      run(0, 6);
      run(1, 3);
      @(negedge clock); gate = 1'b1; sig_in = 1'b1;
      run(1, 1); run(0, 5);
      check("fall_aligned_cnt", last_cnt, 0);

      // randomised windows
      for (int k = 0; k < 30; k++) begin
         sig_mode = 1 + int'($urandom_range(0, 1));
         half     = int'($urandom_range(1, 4));
         phase    = 0;
         run(1, int'($urandom_range(1, 80)));
         run(0, int'($urandom_range(1, 6)));
      end
      run(0, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
